// File: rtl/ring_dco_pkg.sv
// ring_dco_pkg: shared state/phase types and sizing helpers for the ring DCO calibrator
package ring_dco_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, MEAS, EVAL} state_t;
    typedef enum logic [1:0] {SAR, VERIFY, TRACK} phase_t;

    // bits needed to count 0..n-1
    function automatic int ctr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // bits needed to encode ring lengths 0..max_stages
    function automatic int sel_w(input int max_stages);
        return $clog2(max_stages + 1);
    endfunction

endpackage

// File: rtl/ring_dco_edge_sync.sv
// ring_dco_edge_sync: 2-flop synchronizer plus edge flop, one-cycle pulse on each osc_div rise
// Ports: clk_ref/reset (sync, active-high), osc_div (async in), rise (pulse out)
module ring_dco_edge_sync (
    input  logic clk_ref,
    input  logic reset,
    input  logic osc_div,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk_ref) begin
        if (reset) sync <= '0;
        else       sync <= {sync[1:0], osc_div};
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/ring_dco_cal.sv
// ring_dco_cal: SAR calibration and +/-1 LSB drift tracking of the ring DCO tuning code
// Ports: clk_ref/reset (sync, active-high); start, track_en, target, stage_sel_in (control in);
//        osc_div (async divided DCO); code, stage_sel (to DCO); busy, done, lock, meas_count (status)
module ring_dco_cal
    import ring_dco_pkg::*;
#(
    parameter int CODE_W     = 8,
    parameter int CNT_W      = 16,
    parameter int WIN_CYC    = 256,
    parameter int SETTLE_CYC = 16,
    parameter int TOL        = 1,
    parameter int MAX_STAGES = 15,
    parameter int SEL_W      = sel_w(MAX_STAGES)
) (
    input  logic              clk_ref,
    input  logic              reset,
    input  logic              start,
    input  logic              track_en,
    input  logic [CNT_W-1:0]  target,
    input  logic [SEL_W-1:0]  stage_sel_in,
    input  logic              osc_div,
    output logic [CODE_W-1:0] code,
    output logic [SEL_W-1:0]  stage_sel,
    output logic              busy,
    output logic              done,
    output logic              lock,
    output logic [CNT_W-1:0]  meas_count
);

    localparam int TMR_W = ctr_w(WIN_CYC > SETTLE_CYC ? WIN_CYC : SETTLE_CYC);
    localparam int IDX_W = ctr_w(CODE_W);
    localparam logic [TMR_W-1:0]  SET_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WIN_LAST = TMR_W'(WIN_CYC - 1);
    localparam logic [CNT_W:0]    TOL_X    = (CNT_W + 1)'(TOL);
    localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};

    state_t             state, state_n;
    phase_t             phase, phase_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [TMR_W-1:0]   tmr, tmr_n;
    logic [CNT_W-1:0]   cnt, cnt_n, tgt, tgt_n, meas_n;
    logic [CODE_W-1:0]  code_n;
    logic [SEL_W-1:0]   sel_n;
    logic               busy_n, done_n, lock_n, rise, over, under;

    ring_dco_edge_sync u_sync (
        .clk_ref (clk_ref),
        .reset   (reset),
        .osc_div (osc_div),
        .rise    (rise)
    );

    // one extra bit keeps target+TOL and count+TOL from wrapping
    assign over  = {1'b0, cnt} > ({1'b0, tgt} + TOL_X);
    assign under = ({1'b0, cnt} + TOL_X) < {1'b0, tgt};

    always_ff @(posedge clk_ref) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= SAR;
            idx        <= '0;
            tmr        <= '0;
            cnt        <= '0;
            tgt        <= '0;
            code       <= CODE_MID;
            stage_sel  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lock       <= 1'b0;
            meas_count <= '0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            idx        <= idx_n;
            tmr        <= tmr_n;
            cnt        <= cnt_n;
            tgt        <= tgt_n;
            code       <= code_n;
            stage_sel  <= sel_n;
            busy       <= busy_n;
            done       <= done_n;
            lock       <= lock_n;
            meas_count <= meas_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        tmr_n   = tmr + 1'b1;
        cnt_n   = cnt;
        tgt_n   = tgt;
        code_n  = code;
        sel_n   = stage_sel;
        busy_n  = busy;
        done_n  = 1'b0;
        lock_n  = lock;
        meas_n  = meas_count;
        case (state)
            IDLE: if (start) begin
                tgt_n   = target;
                sel_n   = stage_sel_in;
                code_n  = CODE_MID;
                idx_n   = IDX_W'(CODE_W - 1);
                phase_n = SAR;
                tmr_n   = '0;
                busy_n  = 1'b1;
                state_n = SETTLE;
            end
            SETTLE: if (tmr == SET_LAST) begin
                tmr_n   = '0;
                cnt_n   = '0;
                state_n = MEAS;
            end
            MEAS: begin
                cnt_n   = (rise && !(&cnt)) ? cnt + 1'b1 : cnt;
                state_n = (tmr == WIN_LAST) ? EVAL : MEAS;
            end
            EVAL: begin
                meas_n  = cnt;
                lock_n  = !over && !under;
                tmr_n   = '0;
                state_n = SETTLE;
                case (phase)
                    SAR: begin
                        if (cnt > tgt) code_n[idx] = 1'b0;
                        if (idx != '0) begin
                            idx_n = idx - 1'b1;
                            code_n[idx - 1'b1] = 1'b1;
                        end else begin
                            phase_n = VERIFY;
                        end
                    end
                    VERIFY: begin
                        done_n  = 1'b1;
                        phase_n = track_en ? TRACK : VERIFY;
                        state_n = track_en ? SETTLE : IDLE;
                        busy_n  = track_en;
                    end
                    default: begin
                        code_n  = (over && code != '0) ? code - 1'b1 :
                                  (under && !(&code)) ? code + 1'b1 : code;
                        state_n = track_en ? SETTLE : IDLE;
                        busy_n  = track_en;
                    end
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
